answer_entry: RTL

//  1P answer-entry controller. Builds the three 4-bit factors from player buttons and drives

---
 rtl/answer_entry.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/answer_entry.sv
// Answer-entry controller: builds three digit fields from buttons, submits them to the
// checker and tracks verdict, retry hold and per-question time limit.
module answer_entry #(
  parameter logic [3:0]  DIGIT_MAX   = 4'd9,
  parameter logic [31:0] TIME_LIMIT  = 32'd1_500_000_000,
  parameter logic [7:0]  RESP_WAIT   = 8'd8,
  parameter logic [31:0] HOLD_CYCLES = 32'd50_000_000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic        BTN_UP,
  input  logic        BTN_NEXT,
  input  logic        BTN_ENTER,
  input  logic        BTN_CLR,
  input  logic [1:0]  RESULT,
  output logic [3:0]  ANSWER_1,
  output logic [3:0]  ANSWER_2,
  output logic [3:0]  ANSWER_3,
  output logic [11:0] DISP,
  output logic [1:0]  CURSOR,
  output logic [2:0]  STATE_OUT,
  output logic        DONE,
  output logic        TIMEUP
);

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StEdit    = 3'd1,
    StSubmit  = 3'd2,
    StCorrect = 3'd3,
    StWrong   = 3'd4,
    StTimeup  = 3'd5
  } state_e;

  state_e            state_q, state_d;
  logic [2:0][3:0]   field_q, field_d;
  logic [2:0][3:0]   answer_q, answer_d;
  logic [1:0]        cursor_q, cursor_d;
  logic [31:0]       timer_q, timer_d;
  logic [7:0]        wait_q, wait_d;
  logic [31:0]       hold_q, hold_d;
  logic [4:0]        prev_q;
  logic [4:0]        in_now;
  logic [4:0]        edge_hit;
  logic              e_up, e_next, e_enter, e_clr, e_start;
  logic [31:0]       timer_inc;
  logic              time_out;

  // Bit order {start, clr, enter, next, up}
  assign in_now   = {START, BTN_CLR, BTN_ENTER, BTN_NEXT, BTN_UP};
  assign edge_hit = in_now & ~prev_q;
  assign e_up     = edge_hit[0];
  assign e_next   = edge_hit[1];
  assign e_enter  = edge_hit[2];
  assign e_clr    = edge_hit[3];
  assign e_start  = edge_hit[4];

  assign timer_inc = (timer_q != 32'hFFFF_FFFF) ? timer_q + 32'd1 : timer_q;
  assign time_out  = (timer_q >= TIME_LIMIT - 32'd1);

  // Next-state, field editing and counter control
  always_comb begin
    state_d  = state_q;
    field_d  = field_q;
    cursor_d = cursor_q;
    timer_d  = timer_q;
    wait_d   = wait_q;
    hold_d   = hold_q;
    unique case (state_q)
      StIdle, StCorrect, StTimeup: begin
        if (e_start) begin
          state_d  = StEdit;
          field_d  = '0;
          cursor_d = 2'd0;
          timer_d  = 32'd0;
        end
      end
      StEdit: begin
        timer_d = timer_inc;
        if (time_out) begin
          // Expiry beats any button edge in the same cycle
          state_d = StTimeup;
        end else if (e_start) begin
          field_d  = '0;
          cursor_d = 2'd0;
          timer_d  = 32'd0;
        end else if (e_clr) begin
          field_d  = '0;
          cursor_d = 2'd0;
        end else if (e_enter) begin
          if (field_q != '0) begin
            state_d = StSubmit;
            wait_d  = 8'd0;
          end
        end else if (e_next) begin
          cursor_d = (cursor_q == 2'd2) ? 2'd0 : cursor_q + 2'd1;
        end else if (e_up) begin
          field_d[cursor_q] = (field_q[cursor_q] == DIGIT_MAX) ? 4'd0
                                                                : field_q[cursor_q] + 4'd1;
        end
      end
      StSubmit: begin
        if (RESULT == 2'b01) begin
          state_d = StCorrect;
        end else if (RESULT == 2'b11 || wait_q >= RESP_WAIT - 8'd1) begin
          state_d = StWrong;
          hold_d  = 32'd0;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      StWrong: begin
        timer_d = timer_inc;
        if (time_out) begin
          state_d = StTimeup;
        end else if (hold_q >= HOLD_CYCLES - 32'd1) begin
          state_d  = StEdit;
          field_d  = '0;
          cursor_d = 2'd0;
        end else begin
          hold_d = hold_q + 32'd1;
        end
      end
      default: state_d = StIdle;
    endcase
    // Checker only sees the fields once submitted
    answer_d = (state_d == StSubmit || state_d == StCorrect) ? field_d : '0;
  end

  // State, field and counter registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= StIdle;
      field_q  <= '0;
      answer_q <= '0;
      cursor_q <= 2'd0;
      timer_q  <= 32'd0;
      wait_q   <= 8'd0;
      hold_q   <= 32'd0;
      prev_q   <= 5'd0;
    end else begin
      state_q  <= state_d;
      field_q  <= field_d;
      answer_q <= answer_d;
      cursor_q <= cursor_d;
      timer_q  <= timer_d;
      wait_q   <= wait_d;
      hold_q   <= hold_d;
      prev_q   <= in_now;
    end
  end

  assign ANSWER_1  = answer_q[0];
  assign ANSWER_2  = answer_q[1];
  assign ANSWER_3  = answer_q[2];
  assign DISP      = field_q;
  assign CURSOR    = cursor_q;
  assign STATE_OUT = state_q;
  assign DONE      = (state_q == StCorrect);
  assign TIMEUP    = (state_q == StTimeup);

endmodule
